// File: rtl/i2s_transmitter.sv
// I2S serial data transmitter.
// Follows externally generated bclk/lrclk (synchronous to clk_i), buffers PCM
// samples in a small FIFO and shifts one sample per lrclk slot, MSB first,
// with the standard one-bclk delay after each word-select transition.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | disabled; output 0, FIFO flushed, shifter and bit counter clear
// SYNC  | enabled; waiting for the lrclk edge that opens a left slot
// RUN   | one FIFO pop per slot, bits shifted out on bclk falling edges
module i2s_transmitter #(
  parameter int I2S_AUDIO_WORD_LEN  = 24,
  parameter int I2S_AUDIO_FRAME_LEN = 64,
  parameter int I2S_FIFO_DEPTH      = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              enable_i,
  input  logic                              bclk_i,
  input  logic                              lrclk_i,
  input  logic [I2S_AUDIO_WORD_LEN-1:0]     sample_i,
  input  logic                              sample_valid_i,
  output logic                              sample_ready_o,
  output logic                              audio_data_o,
  output logic                              underrun_o,
  output logic [$clog2(I2S_FIFO_DEPTH):0]   fifo_level_o
);

  localparam int PTR_W    = $clog2(I2S_FIFO_DEPTH);
  localparam int LVL_W    = PTR_W + 1;
  localparam int SLOT_LEN = I2S_AUDIO_FRAME_LEN / 2;
  // Bit counter is sized for a full slot so any legal word length fits.
  localparam int CNT_W    = $clog2(SLOT_LEN + 1);

  localparam logic [CNT_W-1:0] WORD_CNT  = CNT_W'(I2S_AUDIO_WORD_LEN);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(I2S_FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_RUN
  } state_t;

  state_t state_q, state_d;

  // Edge detection
  logic bclk_q;
  logic lrclk_q;
  logic fall;
  logic slot_start;

  // FIFO
  logic [I2S_AUDIO_WORD_LEN-1:0] mem [I2S_FIFO_DEPTH];
  logic [PTR_W-1:0]              wr_ptr_q;
  logic [PTR_W-1:0]              rd_ptr_q;
  logic [LVL_W-1:0]              level_q;
  logic [LVL_W-1:0]              level_d;
  logic                          ready_q;
  logic                          fifo_empty;
  logic                          push;
  logic                          pop_req;
  logic                          pop_do;
  logic [I2S_AUDIO_WORD_LEN-1:0] pop_data;

  // Serialiser
  logic [I2S_AUDIO_WORD_LEN-1:0] shift_q;
  logic [CNT_W-1:0]              bit_cnt_q;
  logic                          data_q;
  logic                          underrun_q;

  // lrclk_q holds the word select seen at the previous bclk fall, so a slot
  // boundary is any fall where lrclk_i no longer matches it.
  assign fall       = bclk_q & ~bclk_i;
  assign slot_start = fall & (lrclk_i ^ lrclk_q);

  assign fifo_empty = (level_q == '0);
  assign push       = sample_valid_i & sample_ready_o;
  // The pop looks at the level before any same-cycle push: no bypass path.
  assign pop_do     = pop_req & ~fifo_empty;
  assign pop_data   = fifo_empty ? '0 : mem[rd_ptr_q];

  assign sample_ready_o = enable_i & ready_q;
  assign audio_data_o   = data_q;
  assign underrun_o     = underrun_q;
  assign fifo_level_o   = level_q;

  // Register bclk every cycle and capture lrclk at each bclk fall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
    end else begin
      bclk_q <= bclk_i;
      if (fall) begin
        lrclk_q <= lrclk_i;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and slot pop request.
  always_comb begin
    state_d = state_q;
    pop_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (slot_start && !lrclk_i) begin
          pop_req = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (slot_start) begin
          pop_req = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO occupancy: a simultaneous push and pop leaves the level unchanged.
  always_comb begin
    level_d = level_q;
    if (!enable_i) begin
      level_d = '0;
    end else if (push && !pop_do) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop_do && !push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // FIFO storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= sample_i;
    end
  end

  // FIFO pointers, level and registered not-full flag; disable flushes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      ready_q <= (level_d < DEPTH_LVL);
      if (!enable_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
        if (pop_do) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
      end
    end
  end

  // Serialiser: load at slot start (output held), then one bit per bclk fall
  // until the word is exhausted, zero padding for the rest of the slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      data_q    <= 1'b0;
    end else if (!enable_i || state_q == ST_IDLE) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      data_q    <= 1'b0;
    end else if (pop_req) begin
      shift_q   <= pop_data;
      bit_cnt_q <= '0;
    end else if (fall && state_q == ST_RUN) begin
      if (bit_cnt_q < WORD_CNT) begin
        data_q    <= shift_q[I2S_AUDIO_WORD_LEN-1];
        shift_q   <= shift_q << 1;
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end else begin
        data_q <= 1'b0;
      end
    end
  end

  // Underrun pulse: a slot opened while the FIFO had nothing to give.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= pop_req & fifo_empty;
    end
  end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- Serialises parallel PCM samples onto the I2S data line. It is the upstream counterpart of i2s_receiver.
- bclk/lrclk are driven by clock_generator and are synchronous to clk_i. This block only follows them; it never drives them.
- Samples enter through a valid/ready handshake into a small FIFO. Each lrclk slot pops one sample (left slot first) and shifts it out MSB-first, standard I2S one-bclk delay.

Parameters:
- I2S_AUDIO_WORD_LEN, 24: sample width in bits; must be ≤ I2S_AUDIO_FRAME_LEN/2.
- I2S_AUDIO_FRAME_LEN, 64: bclk periods per stereo frame; slot length = FRAME_LEN/2.
- I2S_FIFO_DEPTH, 4: sample FIFO entries; power of two, ≥ 2.

Ports:
- clk_i, in, 1: system clock.
- rst_ni, in, 1: async active-low reset.
- enable_i, in, 1: block enable.
- bclk_i, in, 1: bit clock from clock_generator.
- lrclk_i, in, 1: word select; 0 = left, 1 = right.
- sample_i, in, WORD_LEN: sample to transmit; two's complement.
- sample_valid_i, in, 1: sample_i valid.
- sample_ready_o, out, 1: FIFO can accept a sample.
- audio_data_o, out, 1: serial data to receiver.
- underrun_o, out, 1: one-clk pulse when a slot starts with an empty FIFO.
- fifo_level_o, out, $clog2(DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset (rst_ni low, asynchronous): all outputs are 0; FIFO is empty; state = IDLE.
- Edge detect: bclk_q and lrclk_q are registered copies of bclk_i and lrclk_i.
  - fall = bclk_q & ~bclk_i.
  - All bit-level actions occur in the clk_i cycle where fall = 1.
  - audio_data_o is registered and updates on the clk_i edge following detection.
  - Bench requirement: bclk half-period ≥ 4 clk_i cycles.
- slot_start = fall, where lrclk_i differs from the lrclk value captured at the previous fall.
- FIFO push: on sample_valid_i & sample_ready_o.
  - sample_ready_o = enable_i & (level < DEPTH), registered from the level.
  - Pointers wrap modulo DEPTH.
  - fifo_level_o increments on push-only, decrements on pop-only, and is unchanged on push+pop.
- States:
  - IDLE: enable_i = 0. Output is 0, FIFO is flushed, shift register and bit counter are cleared.
    - IDLE → SYNC when enable_i = 1.
  - SYNC: waits for a slot_start with lrclk_i = 0 (entering left slot). Output stays 0. No pops and no underrun in this state.
    - On that slot_start, perform a pop and go to RUN.
  - RUN: on every slot_start, pop one entry into the shift register and reset bit_cnt = 0.
    - Output is held at its current value (zero padding) in the slot_start cycle itself.
    - On each following fall with bit_cnt < WORD_LEN: output the shift register MSB, shift left, and increment bit_cnt.
    - Once bit_cnt = WORD_LEN: output 0 for the rest of the slot.
- Pop on an empty FIFO: the shift register loads 0 and underrun_o pulses for 1 clk. Channel alternation is preserved: the next sample goes to the next slot.
- Pop checks the level before any same-cycle push; there is no bypass. A push and a pop on empty in the same cycle give an underrun, and the pushed sample is queued.
- enable_i falling in any state: go to IDLE on the next clk, a mid-word transmission is abandoned, and output = 0 on the next clk.
- lrclk changing before WORD_LEN bits are sent: the remaining bits are dropped and the new slot starts normally.

Test Plan:
- Reset, enable, push 0x20F3FF then 0x20F3FB with a 64-bit frame → i2s_receiver outputs 0x20F3FF on the left slot and 0x20F3FB on the right. Bits 24-31 of each slot are 0. underrun_o never pulses.
- Push 4 samples with no bclk running → level = 4, sample_ready_o = 0. A 5th sample_valid_i is not accepted and the level stays 4.
- Enable with an empty FIFO, then wait through the left slot → underrun_o pulses once at slot start and the receiver gets 0x000000. Push 0x123456 mid-slot → it is transmitted in the right slot.
- Enable asserted while lrclk_i = 1 → no output and no underrun until the lrclk 1→0 transition. The first pushed sample 0xAAAAAA appears on the left slot, MSB one bclk after the edge.
- Deassert enable_i at bit 10 of sample 0xFFFFFF → audio_data_o = 0 within 1 clk, FIFO is flushed (level = 0), and after re-enable it resyncs to the next left slot.
- Push 0x800001 and 0x7FFFFE on consecutive clk cycles while a slot_start coincides with the second push → there is no loss or duplication, and both samples are received in order.
